// File: rtl/cart_mem_sched.sv
// Cartridge SDRAM scheduler: arbitrates ROM-download writes (buffered in a small FIFO)
// against console cartridge reads (one pending slot, one-entry cache), with an operation timeout.
module cart_mem_sched #(
  parameter int WQ_DEPTH = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  input  logic [19:0] cart_a,
  input  logic        cart_rd,
  output logic [7:0]  cart_d,
  output logic        cart_valid,
  output logic [24:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  output logic        mem_rd,
  input  logic [7:0]  mem_dout,
  input  logic        mem_ready,
  output logic [5:0]  cart_pages,
  output logic        err
);

  localparam int PW = (WQ_DEPTH > 1) ? $clog2(WQ_DEPTH) : 1;
  localparam int CW = $clog2(WQ_DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            wait_q, wait_d;
  logic            pend_q, pend_d;
  logic [19:0]     pend_addr_q, pend_addr_d;
  logic            cache_valid_q, cache_valid_d;
  logic [19:0]     cache_addr_q, cache_addr_d;
  logic [7:0]      cache_data_q, cache_data_d;
  logic            stale_q, stale_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic [24:0]     mem_addr_q, mem_addr_d;
  logic [7:0]      mem_din_q, mem_din_d;
  logic            mem_we_q, mem_we_d, mem_rd_q, mem_rd_d;
  logic [7:0]      cart_d_q, cart_d_d;
  logic            cart_valid_q, cart_valid_d;
  logic [5:0]      pages_q, pages_d;
  logic            err_q, err_d;
  logic            pop, push_ok, full;
  logic [24:0]     fifo_addr_q [WQ_DEPTH];
  logic [7:0]      fifo_data_q [WQ_DEPTH];

  // The download-active flag plays no part in scheduling; the FIFO simply drains.
  logic unused_download;
  assign unused_download = ioctl_download;

  always_comb begin
    state_d       = state_q;
    wptr_d        = wptr_q;
    rptr_d        = rptr_q;
    count_d       = count_q;
    pend_d        = pend_q;
    pend_addr_d   = pend_addr_q;
    cache_valid_d = cache_valid_q;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;
    stale_d       = stale_q;
    tmr_d         = tmr_q;
    mem_addr_d    = mem_addr_q;
    mem_din_d     = mem_din_q;
    mem_we_d      = 1'b0;
    mem_rd_d      = 1'b0;
    cart_d_d      = cart_d_q;
    cart_valid_d  = 1'b0;
    pages_d       = pages_q;
    err_d         = err_q;
    pop           = 1'b0;

    if (ioctl_wr) cache_valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop        = 1'b1;
          mem_addr_d = fifo_addr_q[rptr_q];
          mem_din_d  = fifo_data_q[rptr_q];
          mem_we_d   = 1'b1;
          tmr_d      = TW'(1);
          state_d    = WRITE;
        end else if (pend_q) begin
          pend_d = 1'b0;
          if (cache_valid_q && cache_addr_q == pend_addr_q) begin
            cart_d_d     = cache_data_q;
            cart_valid_d = 1'b1;
          end else begin
            mem_addr_d = {5'd0, pend_addr_q};
            mem_rd_d   = 1'b1;
            tmr_d      = TW'(1);
            stale_d    = ioctl_wr;
            state_d    = READ;
          end
        end
      end
      WRITE: begin
        if (mem_ready) begin
          pages_d = mem_addr_q[19:14];
          state_d = IDLE;
        end else if (tmr_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      READ: begin
        if (ioctl_wr) stale_d = 1'b1;
        if (mem_ready) begin
          cart_d_d      = mem_dout;
          cart_valid_d  = 1'b1;
          cache_addr_d  = mem_addr_q[19:0];
          cache_data_d  = mem_dout;
          // A download byte pushed while the read was in flight may target this address.
          cache_valid_d = !(stale_q || ioctl_wr);
          state_d       = IDLE;
        end else if (tmr_q == TW'(TIMEOUT)) begin
          cart_d_d     = 8'hFF;
          cart_valid_d = 1'b1;
          err_d        = 1'b1;
          state_d      = IDLE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cart_rd) begin
      pend_d      = 1'b1;
      pend_addr_d = cart_a;
    end

    // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted then.
    full    = (count_q == CW'(WQ_DEPTH));
    push_ok = ioctl_wr && (!full || pop);
    if (ioctl_wr && !push_ok) err_d = 1'b1;
    if (push_ok) wptr_d = wptr_q + 1'b1;
    if (pop)     rptr_d = rptr_q + 1'b1;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    wait_d = (count_d >= CW'(WQ_DEPTH - 1));
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q       <= IDLE;
      wptr_q        <= '0;
      rptr_q        <= '0;
      count_q       <= '0;
      wait_q        <= 1'b0;
      pend_q        <= 1'b0;
      cache_valid_q <= 1'b0;
      stale_q       <= 1'b0;
      tmr_q         <= '0;
      mem_addr_q    <= '0;
      mem_din_q     <= '0;
      mem_we_q      <= 1'b0;
      mem_rd_q      <= 1'b0;
      cart_d_q      <= 8'hFF;
      cart_valid_q  <= 1'b0;
      pages_q       <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      wptr_q        <= wptr_d;
      rptr_q        <= rptr_d;
      count_q       <= count_d;
      wait_q        <= wait_d;
      pend_q        <= pend_d;
      cache_valid_q <= cache_valid_d;
      stale_q       <= stale_d;
      tmr_q         <= tmr_d;
      mem_addr_q    <= mem_addr_d;
      mem_din_q     <= mem_din_d;
      mem_we_q      <= mem_we_d;
      mem_rd_q      <= mem_rd_d;
      cart_d_q      <= cart_d_d;
      cart_valid_q  <= cart_valid_d;
      pages_q       <= pages_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    pend_addr_q  <= pend_addr_d;
    cache_addr_q <= cache_addr_d;
    cache_data_q <= cache_data_d;
    if (push_ok) begin
      fifo_addr_q[wptr_q] <= ioctl_addr;
      fifo_data_q[wptr_q] <= ioctl_dout;
    end
  end

  assign ioctl_wait = wait_q;
  assign cart_d     = cart_d_q;
  assign cart_valid = cart_valid_q;
  assign mem_addr   = mem_addr_q;
  assign mem_din    = mem_din_q;
  assign mem_we     = mem_we_q;
  assign mem_rd     = mem_rd_q;
  assign cart_pages = pages_q;
  assign err        = err_q;

endmodule
